// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM amount-entry datapath.
package atm_pkg;

  typedef enum logic [2:0] {
    EDIT,
    CONV,
    CHECK,
    VALID,
    ERR
  } state_t;

  localparam logic [1:0] ONES     = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;

  localparam int MAX_AMOUNT_DEFAULT = 255;
  localparam int BCD_W              = 4;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: mod-10 up/down counter with wrap and synchronous clear.
module bcd_digit_counter
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] digit
);

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Wrap in both directions; no carry or borrow leaves this digit.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? DIGIT_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_amount_entry.sv
// Operator amount entry: edit three BCD digits, convert to binary serially,
// range-check, and offer the amount over a valid/ready handshake.
module bcd_amount_entry
  import atm_pkg::*;
#(
  parameter int MAX_AMOUNT = MAX_AMOUNT_DEFAULT,
  parameter int DIGITS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       next_pulse,
  input  logic       enter_pulse,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [1:0] sel,
  output logic       busy,
  output logic [7:0] amount,
  output logic       amount_valid,
  input  logic       amount_ready,
  output logic       err
);

  localparam int             ACC_W     = 10;
  localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_AMOUNT);
  localparam logic [1:0]     LAST_STEP = 2'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       step_q, step_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       amount_q, amount_d;
  logic             amount_valid_q, amount_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             edit_up;
  logic             edit_down;
  logic             clear_digits;
  logic [3:0]       conv_digit;
  logic [ACC_W-1:0] acc_next;

  // Only the highest-priority pulse acts, so up/down are masked by next/enter.
  assign edit_up      = (state_q == EDIT) && up_pulse && !next_pulse && !enter_pulse;
  assign edit_down    = (state_q == EDIT) && down_pulse && !up_pulse && !next_pulse && !enter_pulse;
  assign clear_digits = (state_q == VALID) && amount_ready;

  bcd_digit_counter u_ones (
    .clk   (clk),
    .reset (reset),
    .clear (clear_digits),
    .inc   (edit_up && (sel_q == ONES)),
    .dec   (edit_down && (sel_q == ONES)),
    .digit (ones)
  );

  bcd_digit_counter u_tens (
    .clk   (clk),
    .reset (reset),
    .clear (clear_digits),
    .inc   (edit_up && (sel_q == TENS)),
    .dec   (edit_down && (sel_q == TENS)),
    .digit (tens)
  );

  bcd_digit_counter u_hundreds (
    .clk   (clk),
    .reset (reset),
    .clear (clear_digits),
    .inc   (edit_up && (sel_q == HUNDREDS)),
    .dec   (edit_down && (sel_q == HUNDREDS)),
    .digit (hundreds)
  );

  always_comb begin
    case (step_q)
      2'd0:    conv_digit = hundreds;
      2'd1:    conv_digit = tens;
      default: conv_digit = ones;
    endcase
  end

  assign acc_next = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, conv_digit};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    step_d   = step_q;
    acc_d    = acc_q;
    amount_d = amount_q;
    case (state_q)
      EDIT: begin
        if (enter_pulse) begin
          acc_d   = '0;
          step_d  = '0;
          state_d = CONV;
        end else if (next_pulse) begin
          sel_d = (sel_q == ONES) ? HUNDREDS : sel_q - 2'd1;
        end
      end
      CONV: begin
        acc_d  = acc_next;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (acc_q > MAX_ACC) begin
          state_d = ERR;
        end else begin
          amount_d = acc_q[7:0];
          state_d  = VALID;
        end
      end
      VALID: begin
        if (amount_ready) begin
          sel_d   = HUNDREDS;
          state_d = EDIT;
        end
      end
      ERR: begin
        if (up_pulse || down_pulse || next_pulse || enter_pulse) begin
          state_d = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
    busy_d         = (state_d == CONV) || (state_d == CHECK);
    amount_valid_d = (state_d == VALID);
    err_d          = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= EDIT;
      sel_q          <= HUNDREDS;
      step_q         <= '0;
      acc_q          <= '0;
      amount_q       <= '0;
      amount_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      step_q         <= step_d;
      acc_q          <= acc_d;
      amount_q       <= amount_d;
      amount_valid_q <= amount_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign amount       = amount_q;
  assign amount_valid = amount_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_bcd_amount_entry.sv
// Scoreboard bench for bcd_amount_entry: directed entries push expected results,
// a negedge monitor pops and checks whenever the DUT offers an amount or an error.
module tb_bcd_amount_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       up_pulse, down_pulse, next_pulse, enter_pulse;
  logic [3:0] ones, tens, hundreds;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] amount;
  logic       amount_valid;
  logic       amount_ready;
  logic       err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] amount;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;
  int   total = 0;
  int   bad   = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  logic [7:0] held_amount = '0;

  bcd_amount_entry #(.MAX_AMOUNT(255), .DIGITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .next_pulse   (next_pulse),
    .enter_pulse  (enter_pulse),
    .ones         (ones),
    .tens         (tens),
    .hundreds     (hundreds),
    .sel          (sel),
    .busy         (busy),
    .amount       (amount),
    .amount_valid (amount_valid),
    .amount_ready (amount_ready),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkDigits(input int h, input int t, input int o, input int s);
    checkOutput("hundreds", hundreds, h);
    checkOutput("tens", tens, t);
    checkOutput("ones", ones, o);
    checkOutput("sel", sel, s);
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic n, input logic e);
    up_pulse = u; down_pulse = d; next_pulse = n; enter_pulse = e;
    @(negedge clk);
    up_pulse = 0; down_pulse = 0; next_pulse = 0; enter_pulse = 0;
  endtask

  task automatic pressUp(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1, 0, 0, 0);
  endtask

  // Enter, check busy window and result cycle, then complete the handshake.
  task automatic runConversion(input logic exp_err, input logic [7:0] exp_amt, input int ready_delay,
                               input logic noise, input int h, input int t, input int o, input int s);
    enter_pulse = 1;
    exp_q.push_back('{is_err: exp_err, amount: exp_amt});
    @(negedge clk);
    enter_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("busy_window", busy, 1);
      if (noise && i == 0) begin up_pulse = 1; next_pulse = 1; end
      @(negedge clk);
      up_pulse = 0; next_pulse = 0;
    end
    checkOutput("busy_end", busy, 0);
    checkOutput("valid_at_enter_plus5", amount_valid, !exp_err);
    checkOutput("err_at_enter_plus5", err, exp_err);
    if (!exp_err) begin
      for (int i = 0; i < ready_delay; i++) begin
        if (noise && i == 0) begin up_pulse = 1; next_pulse = 1; end
        @(negedge clk);
        up_pulse = 0; next_pulse = 0;
        checkOutput("valid_stall", amount_valid, 1);
      end
      checkDigits(h, t, o, s);
      amount_ready = 1;
      @(negedge clk);
      amount_ready = 0;
      checkOutput("valid_drop", amount_valid, 0);
      checkDigits(0, 0, 0, 2);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new amount or error is presented.
  always @(negedge clk) begin
    if (amount_valid || err)
      checkOutput("valid_err_exclusive", {31'b0, amount_valid & err}, 0);
    if (amount_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_valid: got amount %0d, expected no output", amount);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("kind_is_valid", exp_item.is_err, 0);
        checkOutput("amount", amount, exp_item.amount);
        held_amount = amount;
      end
    end else if (amount_valid && prev_valid) begin
      checkOutput("amount_held", amount, held_amount);
    end
    if (err && !prev_err) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_err: got err 1, expected no output");
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("kind_is_err", exp_item.is_err, 1);
      end
    end
    prev_valid = amount_valid;
    prev_err   = err;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1; up_pulse = 0; down_pulse = 0; next_pulse = 0; enter_pulse = 0; amount_ready = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    checkDigits(0, 0, 0, 2);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", amount_valid, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_amount", amount, 0);

    $display("[TB] entry 128 with ready stall");
    pressUp(1);
    checkDigits(1, 0, 0, 2);
    applyStimulus(0, 0, 1, 0);
    pressUp(2);
    checkDigits(1, 2, 0, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkDigits(1, 2, 9, 0);
    applyStimulus(0, 1, 0, 0);
    checkDigits(1, 2, 8, 0);
    runConversion(0, 8'h80, 5, 0, 1, 2, 8, 0);

    $display("[TB] entry 255, ready already high");
    pressUp(2);
    applyStimulus(0, 0, 1, 0);
    pressUp(5);
    applyStimulus(0, 0, 1, 0);
    pressUp(5);
    checkDigits(2, 5, 5, 0);
    runConversion(0, 8'hFF, 0, 0, 2, 5, 5, 0);

    $display("[TB] entry 256 raises err, then corrected to 255");
    pressUp(2);
    applyStimulus(0, 0, 1, 0);
    pressUp(5);
    applyStimulus(0, 0, 1, 0);
    pressUp(6);
    checkDigits(2, 5, 6, 0);
    runConversion(1, 8'h00, 0, 0, 2, 5, 6, 0);
    @(negedge clk);
    checkOutput("err_held", err, 1);
    checkOutput("no_valid_in_err", amount_valid, 0);
    checkDigits(2, 5, 6, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("err_cleared", err, 0);
    checkDigits(2, 5, 6, 0);
    applyStimulus(0, 1, 0, 0);
    checkDigits(2, 5, 5, 0);
    runConversion(0, 8'hFF, 2, 0, 2, 5, 5, 0);

    $display("[TB] wrap and priority");
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkDigits(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkDigits(0, 0, 9, 0);
    applyStimulus(1, 0, 0, 0);
    checkDigits(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkDigits(0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    checkDigits(0, 0, 1, 2);

    $display("[TB] pulses ignored during CONV and VALID");
    runConversion(0, 8'h01, 3, 1, 0, 0, 1, 2);

    $display("[TB] reset on second CONV cycle");
    pressUp(1);
    checkDigits(1, 0, 0, 2);
    enter_pulse = 1;
    @(negedge clk);
    enter_pulse = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checkDigits(0, 0, 0, 2);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", amount_valid, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_amount", amount, 0);
    repeat (10) @(negedge clk);
    checkOutput("abort_no_valid", amount_valid, 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
